// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program counter unit.
// Imported by the interface, the return stack and the top.
package pc_pkg;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_RET,
    SRC_ERET,
    SRC_EXC
  } src_t;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_STEP      = 1;
  localparam longint unsigned DEF_RESET = 64'h0;
  localparam longint unsigned DEF_EXC   = 64'h80;
  localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_if.sv
// Control/redirect bundle between fetch, branch resolution and the PC.
// master = requesting logic, slave = pc_unit.
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             stall_i;
  logic             branch_taken_i;
  logic [WIDTH-1:0] branch_target_i;
  logic             jump_i;
  logic [WIDTH-1:0] jump_target_i;
  logic             jr_i;
  logic [WIDTH-1:0] jr_target_i;
  logic             call_i;
  logic             ret_i;
  logic             exc_i;
  logic             eret_i;
  logic             halt_i;
  logic             resume_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus_o;
  logic [WIDTH-1:0] epc_o;
  logic             halted_o;
  logic             flush_o;
  logic             ras_miss_o;

  modport master (
    output stall_i, branch_taken_i, branch_target_i,
    output jump_i, jump_target_i, jr_i, jr_target_i,
    output call_i, ret_i, exc_i, eret_i,
    output halt_i, resume_i,
    input  pc_o, pc_plus_o, epc_o,
    input  halted_o, flush_o, ras_miss_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i,
    input  jump_i, jump_target_i, jr_i, jr_target_i,
    input  call_i, ret_i, exc_i, eret_i,
    input  halt_i, resume_i,
    output pc_o, pc_plus_o, epc_o,
    output halted_o, flush_o, ras_miss_o
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full drops the oldest.
// pop+push together replaces the top entry in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_m1;
  logic [AW:0]      cnt;
  logic             do_pop;

  assign ptr_m1 = ptr - AW'(1);
  assign empty  = (cnt == '0);
  assign top    = mem[ptr_m1];
  assign do_pop = pop && !empty;

  // Pointer and occupancy; count saturates when the ring wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (do_pop && push) begin
      ptr <= ptr;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (cnt != FULL) cnt <= cnt + 1'b1;
    end else if (do_pop) begin
      ptr <= ptr_m1;
      cnt <= cnt - 1'b1;
    end
  end

  // Entry write: overwrite top on pop+push, else next free slot.
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? ptr_m1 : ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with redirect priority, stall/halt and EPC.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter int              STEP      = DEF_STEP,
  parameter longint unsigned RESET_VEC = DEF_RESET,
  parameter longint unsigned EXC_VEC   = DEF_EXC,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_V  = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  state_t           state, nxt_state;
  src_t             sel;
  logic             upd;
  logic [WIDTH-1:0] pc, epc, pc_plus, nxt_pc;
  logic             flush;
  logic [WIDTH-1:0] ret_pc;
  logic             ras_push, ras_pop, miss_n;

  assign pc_plus       = pc + STEP_V;
  assign bus.pc_o      = pc;
  assign bus.pc_plus_o = pc_plus;
  assign bus.epc_o     = epc;
  assign bus.halted_o  = (state == HALT);
  assign bus.flush_o   = flush;

  // Source selection and FSM next state; upd=0 means hold.
  always_comb begin
    nxt_state = state;
    sel       = SRC_SEQ;
    upd       = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.exc_i) begin
          sel = SRC_EXC;
          upd = 1'b1;
        end else if (bus.halt_i) begin
          nxt_state = HALT;
        end else if (!bus.stall_i) begin
          upd = 1'b1;
          if (bus.eret_i)              sel = SRC_ERET;
          else if (bus.ret_i)          sel = SRC_RET;
          else if (bus.jr_i)           sel = SRC_JR;
          else if (bus.jump_i)         sel = SRC_J;
          else if (bus.branch_taken_i) sel = SRC_BR;
          else                         sel = SRC_SEQ;
        end
      end
      HALT: begin
        if (bus.exc_i) begin
          sel       = SRC_EXC;
          upd       = 1'b1;
          nxt_state = RUN;
        end else if (bus.resume_i) begin
          upd       = 1'b1;
          nxt_state = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  // Next-PC mux; redirects load the target with no increment.
  always_comb begin
    nxt_pc = pc_plus;
    unique case (sel)
      SRC_EXC:  nxt_pc = EXC_V;
      SRC_ERET: nxt_pc = epc;
      SRC_RET:  nxt_pc = ret_pc;
      SRC_JR:   nxt_pc = bus.jr_target_i;
      SRC_J:    nxt_pc = bus.jump_target_i;
      SRC_BR:   nxt_pc = bus.branch_target_i;
      default:  nxt_pc = pc_plus;
    endcase
  end

  assign ras_pop = upd && (sel == SRC_RET);

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             miss_q;

  assign ras_push = upd && bus.call_i &&
                    (sel == SRC_J || sel == SRC_JR ||
                     sel == SRC_RET);
  assign ret_pc   = ras_empty ? bus.jr_target_i : ras_top;
  assign miss_n   = ras_pop && ras_empty;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus),
    .top   (ras_top),
    .empty (ras_empty)
  );

  // Miss pulse for a return that found the stack empty.
  always_ff @(posedge clk) begin
    if (rst) miss_q <= 1'b0;
    else     miss_q <= miss_n;
  end

  assign bus.ras_miss_o = miss_q;
`else
  logic unused_ras;

  assign ras_push       = 1'b0;
  assign ret_pc         = bus.jr_target_i;
  assign miss_n         = 1'b0;
  assign unused_ras     = bus.call_i | ras_push | ras_pop | miss_n;
  assign bus.ras_miss_o = 1'b0;
`endif

  // PC, EPC, state and flush registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RST_V;
      epc   <= RST_V;
      flush <= 1'b0;
    end else begin
      state <= nxt_state;
      flush <= upd && (sel != SRC_SEQ);
      if (upd) pc <= nxt_pc;
      if (upd && sel == SRC_EXC) epc <= pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a per-cycle reference model.
// Honours PC_RAS_EN for the return-stack scenarios.
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH     (32),
    .STEP      (1),
    .RESET_VEC (0),
    .EXC_VEC   ('h80),
    .RAS_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state updated per rising edge.
  logic [31:0] m_pc, m_epc;
  bit          m_halt, m_flush, m_miss, m_ok;
  logic [31:0] m_stk[$];

  initial m_ok = 1'b0;

  always @(posedge clk) begin
    logic [31:0] np;
    bit nf, nm, tk;
    if (rst) begin
      m_pc = 0; m_epc = 0; m_halt = 0;
      m_flush = 0; m_miss = 0; m_ok = 1;
      m_stk.delete();
    end else if (m_ok) begin
      np = m_pc; nf = 0; nm = 0; tk = 0;
      if (bus.exc_i) begin
        np = 32'h80; m_epc = m_pc; nf = 1; m_halt = 0;
      end else if (m_halt) begin
        if (bus.resume_i) begin
          m_halt = 0; np = m_pc + 1;
        end
      end else if (bus.halt_i) begin
        m_halt = 1;
      end else if (!bus.stall_i) begin
        nf = 1;
        if (bus.eret_i) np = m_epc;
        else if (bus.ret_i) begin
          tk = 1;
`ifdef PC_RAS_EN
          if (m_stk.size() == 0) begin
            np = bus.jr_target_i; nm = 1;
          end else np = m_stk.pop_back();
`else
          np = bus.jr_target_i;
`endif
        end
        else if (bus.jr_i) begin np = bus.jr_target_i; tk = 1; end
        else if (bus.jump_i) begin np = bus.jump_target_i; tk = 1; end
        else if (bus.branch_taken_i) np = bus.branch_target_i;
        else begin np = m_pc + 1; nf = 0; end
`ifdef PC_RAS_EN
        if (tk && bus.call_i) begin
          if (m_stk.size() == 4) void'(m_stk.pop_front());
          m_stk.push_back(m_pc + 1);
        end
`endif
      end
      m_pc = np; m_flush = nf; m_miss = nm;
    end
  end

  // Per-cycle comparison against the model, away from the edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_pc", bus.pc_o, m_pc);
      chk("m_pc_plus", bus.pc_plus_o, m_pc + 1);
      chk("m_epc", bus.epc_o, m_epc);
      chk("m_halted", 32'(bus.halted_o), 32'(m_halt));
      chk("m_flush", 32'(bus.flush_o), 32'(m_flush));
      chk("m_miss", 32'(bus.ras_miss_o), 32'(m_miss));
    end
  end

  task automatic clr();
    bus.stall_i = 0; bus.branch_taken_i = 0; bus.branch_target_i = 0;
    bus.jump_i = 0; bus.jump_target_i = 0; bus.jr_i = 0;
    bus.jr_target_i = 0; bus.call_i = 0; bus.ret_i = 0;
    bus.exc_i = 0; bus.eret_i = 0; bus.halt_i = 0; bus.resume_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jmp(logic [31:0] t);
    bus.jump_i = 1; bus.jump_target_i = t;
    step(); clr();
  endtask

  initial begin
    logic [31:0] pops [4];
    pops[0] = 6; pops[1] = 5; pops[2] = 4; pops[3] = 3;
    clr(); rst = 1;
    step(); step();
    rst = 0;
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_epc", bus.epc_o, 0);
    chk("rst_halt", 32'(bus.halted_o), 0);
    chk("rst_flush", 32'(bus.flush_o), 0);
    chk("rst_miss", 32'(bus.ras_miss_o), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", bus.pc_o, i);
      chk("seq_flush", 32'(bus.flush_o), 0);
    end
    step(); step();
    chk("pc5", bus.pc_o, 5);
    bus.branch_taken_i = 1; bus.branch_target_i = 'h40;
    step(); clr();
    chk("br_pc", bus.pc_o, 'h40);
    chk("br_flush", 32'(bus.flush_o), 1);
    step();
    chk("br_next", bus.pc_o, 'h41);
    chk("br_flush0", 32'(bus.flush_o), 0);

    jmp(9);
    bus.stall_i = 1; bus.jump_i = 1; bus.jump_target_i = 'h20;
    step(); step();
    chk("stall_pc", bus.pc_o, 9);
    chk("stall_flush", 32'(bus.flush_o), 0);
    bus.stall_i = 0;
    step(); clr();
    chk("unstall_pc", bus.pc_o, 'h20);
    chk("unstall_flush", 32'(bus.flush_o), 1);

    jmp(12);
    bus.stall_i = 1; bus.exc_i = 1;
    step(); clr();
    chk("exc_pc", bus.pc_o, 'h80);
    chk("exc_epc", bus.epc_o, 12);
    bus.eret_i = 1;
    step(); clr();
    chk("eret_pc", bus.pc_o, 12);

    jmp(7);
    bus.halt_i = 1;
    step(); clr();
    chk("halt_pc", bus.pc_o, 7);
    chk("halt_h", 32'(bus.halted_o), 1);
    bus.branch_taken_i = 1; bus.branch_target_i = 'h40;
    step(); step(); clr();
    chk("halt_hold", bus.pc_o, 7);
    chk("halt_flush", 32'(bus.flush_o), 0);
    bus.resume_i = 1;
    step(); clr();
    chk("resume_pc", bus.pc_o, 8);
    chk("resume_h", 32'(bus.halted_o), 0);

    bus.halt_i = 1;
    step(); clr();
    bus.exc_i = 1;
    step(); clr();
    chk("hexc_pc", bus.pc_o, 'h80);
    chk("hexc_epc", bus.epc_o, 8);
    chk("hexc_h", 32'(bus.halted_o), 0);

    jmp(3);
    bus.halt_i = 1; bus.exc_i = 1;
    step(); clr();
    chk("hx_pc", bus.pc_o, 'h80);
    chk("hx_epc", bus.epc_o, 3);
    chk("hx_h", 32'(bus.halted_o), 0);

    bus.eret_i = 1; bus.jr_i = 1; bus.jr_target_i = 'h30;
    bus.jump_i = 1; bus.jump_target_i = 'h50;
    bus.branch_taken_i = 1; bus.branch_target_i = 'h60;
    step();
    chk("pri_eret", bus.pc_o, 3);
    bus.eret_i = 0;
    step();
    chk("pri_jr", bus.pc_o, 'h30);
    bus.jr_i = 0;
    step();
    chk("pri_j", bus.pc_o, 'h50);
    clr();

    jmp(32'hFFFF_FFFF);
    chk("wrap_plus", bus.pc_plus_o, 0);
    step();
    chk("wrap_pc", bus.pc_o, 0);

`ifdef PC_RAS_EN
    jmp(1);
    for (int i = 1; i <= 5; i++) begin
      bus.call_i = 1; bus.jump_i = 1; bus.jump_target_i = i + 1;
      step();
    end
    clr();
    chk("call_pc", bus.pc_o, 6);
    bus.ret_i = 1; bus.jr_target_i = 'h99;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ret_pop", bus.pc_o, pops[k]);
    end
    step(); clr();
    chk("ret_miss_pc", bus.pc_o, 'h99);
    chk("ret_miss", 32'(bus.ras_miss_o), 1);
    step();
    chk("miss_clr", 32'(bus.ras_miss_o), 0);
`else
    bus.ret_i = 1; bus.call_i = 1; bus.jr_target_i = 'h77;
    step();
    chk("ret_jr", bus.pc_o, 'h77);
    chk("ret_nomiss", 32'(bus.ras_miss_o), 0);
    bus.jr_target_i = 'h78;
    step(); clr();
    chk("ret_jr2", bus.pc_o, 'h78);
`endif

    bus.exc_i = 1; rst = 1;
    step(); clr(); rst = 0;
    chk("rst2_pc", bus.pc_o, 0);
    chk("rst2_epc", bus.epc_o, 0);
    chk("rst2_flush", 32'(bus.flush_o), 0);
    step();
    chk("rst2_seq", bus.pc_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
